// File: rtl/text_pkg.sv
// text_pkg: shared constants and types for the text-mode renderer.
//   CHAR_W/CHAR_H  glyph cell size in pixels
//   ROW_STRIDE     words per character row in text_ram
//   LATENCY        clocks from x/y/sync sample to rgb/sync output
//   attr_t         attribute byte layout {blink, bg[2:0], fg[3:0]}
//   PALETTE        16-entry CGA colour table, {r,g,b} 4 bits each
package text_pkg;

    localparam int unsigned CHAR_W     = 8;
    localparam int unsigned CHAR_H     = 16;
    localparam int unsigned ROW_STRIDE = 32;
    localparam int unsigned LATENCY    = 5;

    typedef struct packed {
        logic       blink;  // attr[7]
        logic [2:0] bg;     // attr[6:4]
        logic [3:0] fg;     // attr[3:0]
    } attr_t;

    // Index 15 is the leftmost element of the packed array.
    localparam logic [15:0][11:0] PALETTE = {
        12'hFFF, 12'hFF5, 12'hF5F, 12'hF55,
        12'h5FF, 12'h5F5, 12'h55F, 12'h555,
        12'hAAA, 12'hA50, 12'hA0A, 12'hA00,
        12'h0AA, 12'h0A0, 12'h00A, 12'h000
    };

    // Colour index for one pixel; a blinking cell in its off phase shows
    // background in place of foreground.
    function automatic logic [3:0] pixel_index(input attr_t a,
                                               input logic  bit_on,
                                               input logic  blink_phase);
        logic [3:0] bg_idx;
        bg_idx = {1'b0, a.bg};
        if (!bit_on || (a.blink && blink_phase)) begin
            return bg_idx;
        end
        return a.fg;
    endfunction

endpackage

// File: rtl/text_palette.sv
// text_palette: registered 4-bit colour index -> 12-bit RGB lookup.
//   clk      in   pixel clock
//   rst      in   synchronous active-high reset
//   valid_i  in   pixel is inside the text area; otherwise output black
//   idx_i    in   palette index
//   rgb_o    out  registered {r,g,b}
module text_palette
    import text_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [3:0]  idx_i,
    output logic [11:0] rgb_o
);

    logic [11:0] rgb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= valid_i ? PALETTE[idx_i] : '0;
        end
    end

    assign rgb_o = rgb_q;

endmodule

// File: rtl/text_renderer.sv
// text_renderer: read side of the text_ram character buffer. Turns VGA
// timing into RGB pixels via a 5-stage pipeline:
//   E1 address/side-band register, E2 RAM read, E3 font address,
//   E4 ROM read, E5 palette lookup.
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   x, y, de_in, hs_in, vs_in  timing generator inputs
//   ram_adb, ram_ceb, ram_oce  text_ram port B address/enables
//   ram_dout                 text_ram read data {attr, char}
//   font_ad, font_dout       font_rom address {char, row} and glyph row
//   rgb, de_out, hs_out, vs_out  pixel and sync outputs, LATENCY aligned
module text_renderer
    import text_pkg::*;
#(
    parameter int unsigned TEXT_COLS    = 30,
    parameter int unsigned TEXT_ROWS    = 17,
    parameter int unsigned BLINK_FRAMES = 32,
    parameter logic        SYNC_POL     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic [9:0]  ram_adb,
    output logic        ram_ceb,
    output logic        ram_oce,
    input  logic [15:0] ram_dout,
    output logic [11:0] font_ad,
    input  logic [7:0]  font_dout,
    output logic [11:0] rgb,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [4:0] col;
    logic [4:0] row;
    logic       in_range;

    assign col = x[7:3];
    assign row = y[8:4];

    // The x/y range checks stop wrapped coordinates from aliasing onto
    // real cells; the address itself is issued unconditionally.
    assign in_range = de_in && (x[9:8] == 2'b00) && !y[9]
                   && (32'(col) < TEXT_COLS) && (32'(row) < TEXT_ROWS);

    // Pipeline registers
    logic [9:0]               adb_q;
    logic [3:0][2:0]          px_q;     // px_q[3] is aligned with E5
    logic [1:0][3:0]          grow_q;   // grow_q[1] is aligned with E3
    logic [3:0]               inr_q;    // inr_q[3] is aligned with E5
    logic [11:0]              font_ad_q;
    attr_t                    attr_q;
    attr_t                    attr_e4_q;
    logic [LATENCY-1:0]       de_sr_q;
    logic [LATENCY-1:0]       hs_sr_q;
    logic [LATENCY-1:0]       vs_sr_q;

    // Blink state
    logic             vs_prev_q;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             blink_q, blink_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            adb_q     <= '0;
            px_q      <= '0;
            grow_q    <= '0;
            inr_q     <= '0;
            font_ad_q <= '0;
            attr_q    <= '0;
            attr_e4_q <= '0;
            de_sr_q   <= '0;
            // Inactive level so a mid-frame reset cannot emit a sync pulse.
            hs_sr_q   <= {LATENCY{~SYNC_POL}};
            vs_sr_q   <= {LATENCY{~SYNC_POL}};
        end else begin
            adb_q     <= {row, col};
            px_q      <= {px_q[2:0], x[2:0]};
            grow_q    <= {grow_q[0], y[3:0]};
            inr_q     <= {inr_q[2:0], in_range};
            font_ad_q <= {ram_dout[7:0], grow_q[1]};
            attr_q    <= attr_t'(ram_dout[15:8]);
            attr_e4_q <= attr_q;
            de_sr_q   <= {de_sr_q[LATENCY-2:0], de_in};
            hs_sr_q   <= {hs_sr_q[LATENCY-2:0], hs_in};
            vs_sr_q   <= {vs_sr_q[LATENCY-2:0], vs_in};
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        // Leading edge of vs: transition into the active level.
        if ((vs_in == SYNC_POL) && (vs_prev_q != SYNC_POL)) begin
            if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_q   <= ~SYNC_POL;
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            vs_prev_q   <= vs_in;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // E5: glyph bit select (bit 7 = leftmost pixel) and colour lookup
    logic       pix_bit;
    logic [3:0] pix_idx;

    assign pix_bit = font_dout[3'd7 - px_q[3]];
    assign pix_idx = pixel_index(attr_e4_q, pix_bit, blink_q);

    text_palette u_palette (
        .clk     (clk),
        .rst     (rst),
        .valid_i (inr_q[3]),
        .idx_i   (pix_idx),
        .rgb_o   (rgb)
    );

    assign ram_adb = adb_q;
    assign ram_ceb = 1'b1;
    assign ram_oce = 1'b1;
    assign font_ad = font_ad_q;
    assign de_out  = de_sr_q[LATENCY-1];
    assign hs_out  = hs_sr_q[LATENCY-1];
    assign vs_out  = vs_sr_q[LATENCY-1];

endmodule

// File: tb/tb_text_renderer.sv
module tb_text_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x, y;
    logic        de_in, hs_in, vs_in;
    logic [9:0]  ram_adb;
    logic        ram_ceb, ram_oce;
    logic [15:0] ram_dout;
    logic [11:0] font_ad;
    logic [7:0]  font_dout;
    logic [11:0] rgb;
    logic        de_out, hs_out, vs_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem      [1024];
    logic [7:0]  font_mem [4096];

    always #5 clk = ~clk;

    text_renderer #(
        .TEXT_COLS    (30),
        .TEXT_ROWS    (17),
        .BLINK_FRAMES (2),
        .SYNC_POL     (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .de_in     (de_in),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .ram_adb   (ram_adb),
        .ram_ceb   (ram_ceb),
        .ram_oce   (ram_oce),
        .ram_dout  (ram_dout),
        .font_ad   (font_ad),
        .font_dout (font_dout),
        .rgb       (rgb),
        .de_out    (de_out),
        .hs_out    (hs_out),
        .vs_out    (vs_out)
    );

    // Synchronous RAM and ROM models: data one clock after the address.
    always @(posedge clk) begin
        if (ram_ceb) ram_dout <= mem[ram_adb];
        font_dout <= font_mem[font_ad];
    end

    // Drive one pixel, let the pipeline drain, return the observed rgb.
    task automatic sample_pixel(input logic [9:0] px, input logic [9:0] py,
                                input logic de, output logic [11:0] obs);
        @(negedge clk);
        x = px; y = py; de_in = de;
        @(negedge clk);
        x = '0; y = '0; de_in = 1'b0;
        repeat (4) @(negedge clk);
        obs = rgb;
    endtask

    task automatic pulse_vs();
        @(negedge clk); vs_in = 1'b0;
        @(negedge clk); vs_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", rgb); end
        checks++; if (de_out !== 1'b0) begin errors++; $display("FAIL reset_de got %b want 0", de_out); end
        checks++; if (hs_out !== 1'b1 || vs_out !== 1'b1) begin errors++; $display("FAIL reset_sync got hs=%b vs=%b want 1 1", hs_out, vs_out); end
        checks++; if (ram_adb !== 10'h000) begin errors++; $display("FAIL reset_adb got %h want 000", ram_adb); end
        checks++; if (font_ad !== 12'h000) begin errors++; $display("FAIL reset_font_ad got %h want 000", font_ad); end
        checks++; if (ram_ceb !== 1'b1 || ram_oce !== 1'b1) begin errors++; $display("FAIL reset_enables got ceb=%b oce=%b want 1 1", ram_ceb, ram_oce); end
        rst = 1'b0;
    endtask

    task automatic test_glyph_row();
        logic [11:0] exp [8];
        exp = '{12'h00A, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h00A};
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i >= 5) begin
                checks++;
                if (rgb !== exp[i-5]) begin errors++; $display("FAIL glyph_px%0d got %h want %h", i-5, rgb, exp[i-5]); end
                checks++;
                if (de_out !== 1'b1) begin errors++; $display("FAIL glyph_de%0d got %b want 1", i-5, de_out); end
            end
            if (i < 8) begin x = 10'(i); y = '0; de_in = 1'b1; end
            else begin x = '0; de_in = 1'b0; end
        end
    endtask

    task automatic test_addressing();
        logic [11:0] obs;
        @(negedge clk);
        x = 10'd16; y = 10'd16; de_in = 1'b1;
        @(negedge clk);
        checks++; if (ram_adb !== 10'h022) begin errors++; $display("FAIL addr_adb got %h want 022", ram_adb); end
        repeat (2) @(negedge clk);
        checks++; if (font_ad !== 12'h300) begin errors++; $display("FAIL addr_font_ad got %h want 300", font_ad); end
        repeat (2) @(negedge clk);
        checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL addr_fg got %h want FFF", rgb); end
        de_in = 1'b0;
        sample_pixel(10'd20, 10'd16, 1'b1, obs);
        checks++; if (obs !== 12'h000) begin errors++; $display("FAIL addr_bg got %h want 000", obs); end
    endtask

    task automatic test_range();
        logic [11:0] obs;
        sample_pixel(10'd232, 10'd0, 1'b1, obs);
        checks++; if (obs !== 12'hFFF) begin errors++; $display("FAIL range_col29 got %h want FFF", obs); end
        sample_pixel(10'd240, 10'd0, 1'b1, obs);
        checks++; if (obs !== 12'h000) begin errors++; $display("FAIL range_col30 got %h want 000", obs); end
        sample_pixel(10'd256, 10'd0, 1'b1, obs);
        checks++; if (obs !== 12'h000) begin errors++; $display("FAIL range_x256 got %h want 000", obs); end
        sample_pixel(10'd0, 10'd256, 1'b1, obs);
        checks++; if (obs !== 12'hFFF) begin errors++; $display("FAIL range_row16 got %h want FFF", obs); end
        sample_pixel(10'd0, 10'd272, 1'b1, obs);
        checks++; if (obs !== 12'h000) begin errors++; $display("FAIL range_row17 got %h want 000", obs); end
        sample_pixel(10'd0, 10'd0, 1'b0, obs);
        checks++; if (obs !== 12'h000) begin errors++; $display("FAIL range_de0 got %h want 000", obs); end
    endtask

    task automatic test_blink();
        logic [11:0] obs;
        sample_pixel(10'd24, 10'd32, 1'b1, obs);
        checks++; if (obs !== 12'hFFF) begin errors++; $display("FAIL blink_start got %h want FFF", obs); end
        pulse_vs();
        sample_pixel(10'd24, 10'd32, 1'b1, obs);
        checks++; if (obs !== 12'hFFF) begin errors++; $display("FAIL blink_one_pulse got %h want FFF", obs); end
        pulse_vs();
        sample_pixel(10'd24, 10'd32, 1'b1, obs);
        checks++; if (obs !== 12'h000) begin errors++; $display("FAIL blink_off got %h want 000", obs); end
        pulse_vs();
        pulse_vs();
        sample_pixel(10'd24, 10'd32, 1'b1, obs);
        checks++; if (obs !== 12'hFFF) begin errors++; $display("FAIL blink_on got %h want FFF", obs); end
    endtask

    task automatic test_reset_midline();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            x = 10'd16; y = 10'd16; de_in = 1'b1; vs_in = 1'b1;
            hs_in = (i >= 6) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        hs_in = 1'b1; rst = 1'b1;
        @(negedge clk);
        checks++; if (ram_adb !== 10'h000 || font_ad !== 12'h000) begin errors++; $display("FAIL midrst_addr got adb=%h fad=%h want 000 000", ram_adb, font_ad); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (de_out !== 1'b0 || hs_out !== 1'b1 || vs_out !== 1'b1 || rgb !== 12'h000) begin
                errors++;
                $display("FAIL midrst_out%0d got de=%b hs=%b vs=%b rgb=%h want 0 1 1 000", k, de_out, hs_out, vs_out, rgb);
            end
            rst = 1'b0;
        end
        @(negedge clk);
        checks++; if (de_out !== 1'b1 || rgb !== 12'hFFF) begin errors++; $display("FAIL midrst_resume got de=%b rgb=%h want 1 FFF", de_out, rgb); end
        de_in = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_sync_delay();
        localparam int N = 40;
        logic de_h [N];
        logic hs_h [N];
        logic vs_h [N];
        for (int i = 0; i < N + 5; i++) begin
            @(negedge clk);
            if (i >= 5) begin
                checks++;
                if (de_out !== de_h[i-5] || hs_out !== hs_h[i-5] || vs_out !== vs_h[i-5]) begin
                    errors++;
                    $display("FAIL sync_delay%0d got de=%b hs=%b vs=%b want %b %b %b",
                             i-5, de_out, hs_out, vs_out, de_h[i-5], hs_h[i-5], vs_h[i-5]);
                end
            end
            if (i < N) begin
                x = 10'($urandom_range(0, 1023));
                y = 10'($urandom_range(0, 1023));
                de_h[i] = 1'($urandom_range(0, 1));
                hs_h[i] = 1'($urandom_range(0, 1));
                vs_h[i] = 1'($urandom_range(0, 1));
                de_in = de_h[i]; hs_in = hs_h[i]; vs_in = vs_h[i];
            end else begin
                de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 4096; i++) font_mem[i] = '0;
        mem[10'h000] = 16'h01C9;
        mem[10'h022] = 16'h0F30;
        mem[10'h01D] = 16'h0FC9;        // row 0, col 29
        mem[10'h01E] = 16'h0FC9;        // row 0, col 30 (outside text area)
        mem[10'h200] = 16'h0FC9;        // row 16, col 0
        mem[10'h220] = 16'h0FC9;        // row 17, col 0 (outside text area)
        mem[10'h043] = 16'h8F41;        // row 2, col 3, blinking
        font_mem[12'hC90] = 8'h81;
        font_mem[12'h300] = 8'hF0;
        font_mem[12'h410] = 8'h80;
        ram_dout = '0; font_dout = '0;
        x = '0; y = '0; de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1; rst = 1'b1;

        test_reset();
        test_glyph_row();
        test_addressing();
        test_range();
        test_blink();
        test_reset_midline();
        test_sync_delay();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
